// File: rtl/imem_loader.sv
// Framed host byte stream to instruction-memory word writer.
// Holds the CPU until a whole frame has loaded with a matching XOR checksum.
module imem_loader #(
   parameter int unsigned ADDR_WIDTH = 8,
   parameter logic [7:0]  SYNC_BYTE  = 8'hA5,
   parameter int unsigned BASE_ADDR  = 0
) (
   input  logic                  clk,
   input  logic                  rst_n,
   input  logic [7:0]            in_data,
   input  logic                  in_valid,
   output logic                  in_ready,
   output logic                  imem_we,
   output logic [ADDR_WIDTH-1:0] imem_addr,
   output logic [31:0]           imem_wdata,
   output logic                  cpu_hold,
   output logic                  done,
   output logic                  err,
   output logic [15:0]           words_loaded
);

   localparam int unsigned LEN_LIMIT = (1 << ADDR_WIDTH) - BASE_ADDR;

   typedef enum logic [2:0] {
      S_IDLE, S_LEN_HI, S_LEN_LO, S_DATA, S_CSUM, S_DONE, S_ERROR
   } state_t;

   state_t                state_q, state_d;
   logic [7:0]            len_hi_q, len_hi_d;
   logic [15:0]           len_q, len_d;
   logic [1:0]            byte_cnt_q, byte_cnt_d;
   logic [23:0]           asm_q, asm_d;
   logic [7:0]            csum_q, csum_d;
   logic                  imem_we_q, imem_we_d;
   logic [ADDR_WIDTH-1:0] imem_addr_q, imem_addr_d;
   logic [31:0]           imem_wdata_q, imem_wdata_d;
   logic                  cpu_hold_q, cpu_hold_d;
   logic                  done_q, done_d;
   logic                  err_q, err_d;
   logic [15:0]           words_q, words_d;
   logic                  in_ready_q;
   logic                  accept;
   logic [15:0]           len_rx;

   assign accept = in_valid && in_ready_q;
   assign len_rx = {len_hi_q, in_data};

   // Next-state and output decode
   always_comb begin
      state_d      = state_q;
      len_hi_d     = len_hi_q;
      len_d        = len_q;
      byte_cnt_d   = byte_cnt_q;
      asm_d        = asm_q;
      csum_d       = csum_q;
      imem_we_d    = 1'b0;
      imem_addr_d  = imem_addr_q;
      imem_wdata_d = imem_wdata_q;
      words_d      = words_q;

      if (accept) begin
         case (state_q)
            S_IDLE, S_DONE, S_ERROR: begin
               if (in_data == SYNC_BYTE) begin
                  state_d    = S_LEN_HI;
                  csum_d     = 8'h00;
                  asm_d      = 24'h0;
                  byte_cnt_d = 2'd0;
                  words_d    = 16'd0;
               end
            end
            S_LEN_HI: begin
               len_hi_d = in_data;
               state_d  = S_LEN_LO;
            end
            S_LEN_LO: begin
               len_d = len_rx;
               if (32'(len_rx) > LEN_LIMIT)  state_d = S_ERROR;
               else if (len_rx == 16'd0)     state_d = S_CSUM;
               else                          state_d = S_DATA;
            end
            S_DATA: begin
               csum_d     = csum_q ^ in_data;
               byte_cnt_d = byte_cnt_q + 2'd1;
               if (byte_cnt_q == 2'd3) begin
                  imem_we_d    = 1'b1;
                  imem_addr_d  = ADDR_WIDTH'(BASE_ADDR) + ADDR_WIDTH'(words_q);
                  imem_wdata_d = {asm_q, in_data};
                  words_d      = words_q + 16'd1;
                  if (words_q + 16'd1 == len_q) state_d = S_CSUM;
               end else begin
                  asm_d = {asm_q[15:0], in_data};
               end
            end
            S_CSUM: state_d = (in_data == csum_q) ? S_DONE : S_ERROR;
            default: state_d = S_IDLE;
         endcase
      end

      done_d     = (state_d == S_DONE);
      err_d      = (state_d == S_ERROR);
      cpu_hold_d = (state_d != S_DONE);
   end

   // State and output registers, synchronous reset
   always_ff @(posedge clk) begin
      if (!rst_n) begin
         state_q      <= S_IDLE;
         len_hi_q     <= 8'h00;
         len_q        <= 16'd0;
         byte_cnt_q   <= 2'd0;
         asm_q        <= 24'h0;
         csum_q       <= 8'h00;
         imem_we_q    <= 1'b0;
         imem_addr_q  <= ADDR_WIDTH'(BASE_ADDR);
         imem_wdata_q <= 32'h0;
         cpu_hold_q   <= 1'b1;
         done_q       <= 1'b0;
         err_q        <= 1'b0;
         words_q      <= 16'd0;
         in_ready_q   <= 1'b0;
      end else begin
         state_q      <= state_d;
         len_hi_q     <= len_hi_d;
         len_q        <= len_d;
         byte_cnt_q   <= byte_cnt_d;
         asm_q        <= asm_d;
         csum_q       <= csum_d;
         imem_we_q    <= imem_we_d;
         imem_addr_q  <= imem_addr_d;
         imem_wdata_q <= imem_wdata_d;
         cpu_hold_q   <= cpu_hold_d;
         done_q       <= done_d;
         err_q        <= err_d;
         words_q      <= words_d;
         in_ready_q   <= 1'b1;
      end
   end

   assign in_ready     = in_ready_q;
   assign imem_we      = imem_we_q;
   assign imem_addr    = imem_addr_q;
   assign imem_wdata   = imem_wdata_q;
   assign cpu_hold     = cpu_hold_q;
   assign done         = done_q;
   assign err          = err_q;
   assign words_loaded = words_q;

endmodule

// File: doc/imem_loader.md
Name: imem_loader

Overview:
- Writer side of the instruction-memory read path used by the fetch stage: receives a framed byte stream from a host and writes it, word by word, into instruction memory.
- Holds the CPU pipeline (cpu_hold) until a complete frame has loaded and its checksum matches.
- Sits beside the fetch stage. Its write port drives the instruction memory's write side.

Parameters:
ADDR_WIDTH, 8, instruction-memory word-address width; depth = 2^ADDR_WIDTH words
SYNC_BYTE, 8'hA5, frame start marker
BASE_ADDR, 0, word address of the first payload word

Ports:
clk  input  1  system clock, rising edge
rst_n  input  1  synchronous active-low reset
in_data  input  8  host byte
in_valid  input  1  host byte valid
in_ready  output  1  loader accepts byte; a byte transfers when in_valid & in_ready at a clk edge
imem_we  output  1  instruction-memory write strobe, one cycle per word
imem_addr  output  ADDR_WIDTH  word write address
imem_wdata  output  32  word write data, big-endian assembled
cpu_hold  output  1  1 = pipeline held
done  output  1  last frame loaded with good checksum
err  output  1  last frame failed (bad length or checksum)
words_loaded  output  16  words written in the current or last frame

Behaviour:
- Reset (rst_n=0 at a clk edge), from any state including mid-frame:
  - State goes to IDLE.
  - Outputs: imem_we=0, imem_addr=BASE_ADDR, imem_wdata=0, cpu_hold=1, done=0, err=0, words_loaded=0, in_ready=0.
  - in_ready is 1 from the first cycle after reset releases.
- Frame format: SYNC_BYTE, LEN_HI, LEN_LO, LEN×4 payload bytes (MSB first per word), CSUM.
  - CSUM is the XOR of all payload bytes. For LEN=0 the expected CSUM is 0x00.
- States:
  - IDLE: discard any byte other than SYNC_BYTE. On SYNC_BYTE, go to LEN_HI and clear done, err and words_loaded.
  - LEN_HI: latch the high length byte, go to LEN_LO.
  - LEN_LO: latch the low length byte.
    - LEN > 2^ADDR_WIDTH − BASE_ADDR: go to ERROR.
    - LEN = 0: go to CSUM.
    - Otherwise: go to DATA.
  - DATA:
    - Shift bytes into a 32-bit assembly register and XOR each byte into the running checksum.
    - On the 4th byte of a word, the next cycle drives imem_we=1 with imem_addr = BASE_ADDR + word index and imem_wdata = the assembled word. Write latency is 1 cycle after the accepting edge.
    - words_loaded increments with that write.
    - After the last word's 4th byte, go to CSUM.
  - CSUM: compare the received byte with the running XOR. Match → DONE; mismatch → ERROR.
  - DONE: done=1, cpu_hold=0. SYNC_BYTE restarts loading: state → LEN_HI, cpu_hold=1 the next cycle, done cleared. Other bytes are discarded.
  - ERROR: err=1, cpu_hold=1. SYNC_BYTE restarts loading as from DONE. Other bytes are discarded.
- in_ready=1 in every state outside reset; the loader never back-pressures. Bubbles on in_valid are allowed anywhere and leave state unchanged.
- Checksum and the assembly register clear on each accepted SYNC_BYTE.
- A SYNC_BYTE value inside a length, payload or CSUM field is data, not a restart.
- Words already written before an ERROR remain in memory; no rollback.
- imem_addr holds its last value between writes; imem_we is never high for more than 1 consecutive cycle.
- No address wrap is possible: the length check rejects oversize frames before any write.

Test Plan:
1. Frame A5 00 02 20 08 00 05 8C 09 00 04 AC, in_valid continuous → writes addr 0 = 0x20080005, then addr 1 = 0x8C090004. Final state: done=1, err=0, cpu_hold=0, words_loaded=2.
2. Same frame with CSUM AD → both writes occur; err=1, done=0, cpu_hold=1. Then resend the scenario-1 frame → done=1, cpu_hold=0.
3. Frame A5 00 00 00 → no imem_we pulse; done=1, words_loaded=0, cpu_hold=0.
4. Bytes 00 FF 13 before the scenario-1 frame, in_valid low for 1–3 random cycles between bytes → same writes and flags as scenario 1.
5. ADDR_WIDTH=8, BASE_ADDR=0, header A5 01 01 → err=1 immediately after the LEN_LO byte, no imem_we pulse.
6. rst_n low for 1 cycle after the 5th payload byte of the scenario-1 frame:
   - Immediately after reset: all outputs at reset values, in particular cpu_hold=1 and imem_addr=0.
   - A complete frame sent afterwards loads from addr 0 with done=1.
